// File: rtl/seq_serializer.sv
// Parallel-to-serial stimulus stage: loads a WIDTH-bit pattern and shifts it out MSB-first.
// Optional macro SEQ_SERIALIZER_LOOP_EN adds loop_mode to replay the captured pattern continuously.
module seq_serializer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [WIDTH-1:0]        load_data,
  output logic                    load_ready,
  input  logic                    stall,
`ifdef SEQ_SERIALIZER_LOOP_EN
  input  logic                    loop_mode,
`endif
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(WIDTH):0]  bits_left
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state, w_state_nx;
  logic [WIDTH-1:0]   r_shreg, w_shreg_nx;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nx;
  logic               r_vld,   w_vld_nx;
  logic               r_done,  w_done_nx;
`ifdef SEQ_SERIALIZER_LOOP_EN
  logic [WIDTH-1:0]   r_copy,  w_copy_nx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
      r_done  <= 1'b0;
`ifdef SEQ_SERIALIZER_LOOP_EN
      r_copy  <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_shreg <= w_shreg_nx;
      r_cnt   <= w_cnt_nx;
      r_vld   <= w_vld_nx;
      r_done  <= w_done_nx;
`ifdef SEQ_SERIALIZER_LOOP_EN
      r_copy  <= w_copy_nx;
`endif
    end
  end

  // The shift register is cleared when a pattern finishes, so its MSB is the
  // registered serial output and is zero whenever bit_valid is low.
  always_comb begin
    w_state_nx = r_state;
    w_shreg_nx = r_shreg;
    w_cnt_nx   = r_cnt;
    w_vld_nx   = r_vld;
    w_done_nx  = 1'b0;
`ifdef SEQ_SERIALIZER_LOOP_EN
    w_copy_nx  = r_copy;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (load_valid) begin
          w_shreg_nx = load_data;
          w_cnt_nx   = CNT_W'(WIDTH);
          w_vld_nx   = 1'b1;
          w_state_nx = S_SHIFT;
`ifdef SEQ_SERIALIZER_LOOP_EN
          w_copy_nx  = load_data;
`endif
        end
      end
      S_SHIFT: begin
        if (!stall) begin
          if (r_cnt > CNT_W'(1)) begin
            w_shreg_nx = {r_shreg[WIDTH-2:0], 1'b0};
            w_cnt_nx   = r_cnt - CNT_W'(1);
          end else begin
            w_done_nx = 1'b1;
`ifdef SEQ_SERIALIZER_LOOP_EN
            if (loop_mode) begin
              w_shreg_nx = r_copy;
              w_cnt_nx   = CNT_W'(WIDTH);
            end else begin
              w_shreg_nx = '0;
              w_cnt_nx   = '0;
              w_vld_nx   = 1'b0;
              w_state_nx = S_DONE;
            end
`else
            w_shreg_nx = '0;
            w_cnt_nx   = '0;
            w_vld_nx   = 1'b0;
            w_state_nx = S_DONE;
`endif
          end
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign load_ready = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign bit_out    = r_shreg[WIDTH-1];
  assign bit_valid  = r_vld;
  assign done       = r_done;
  assign bits_left  = r_cnt;

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
Parallel-to-serial stimulus stage that sits directly upstream of the bit-serial sequence-detector FSM. It accepts a WIDTH-bit pattern through a valid/ready load handshake and drives it MSB-first, one bit per clock, on a single-bit line that feeds the FSM's serial input. It also flags when each pattern has been fully sent, so several serializer/FSM pairs can run side by side from one clock and reset.

Parameters:
WIDTH, 32, pattern length in bits; legal range 2..64
CNT_W, derived localparam = clog2(WIDTH)+1, width of the bits-remaining counter

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  reset, asynchronous, active-high; clears all state immediately
load_valid  in  1  pattern offered on load_data
load_data  in  WIDTH  pattern; bit WIDTH-1 is sent first
load_ready  out  1  serializer can accept a pattern (high only in IDLE)
stall  in  1  hold the current bit for one more cycle (SHIFT only)
bit_out  out  1  serial data to the downstream FSM inp
bit_valid  out  1  bit_out carries a pattern bit
busy  out  1  high in SHIFT and DONE
done  out  1  single-cycle pulse after the last bit
bits_left  out  CNT_W  bits remaining, including the bit currently on bit_out

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; shift register=0; bits_left=0.
  - bit_out=0, bit_valid=0, busy=0, done=0, load_ready=1.
- States: IDLE, SHIFT, DONE. All outputs are registered except load_ready and busy, which decode the state.
- IDLE:
  - load_ready=1.
  - On a rising edge with load_valid=1: shift register<=load_data, bits_left<=WIDTH, bit_out<=load_data[WIDTH-1], bit_valid<=1, go to SHIFT.
  - stall is ignored.
- SHIFT:
  - load_ready=0; load_valid is ignored and no capture occurs.
  - Edge with stall=1: hold all state; the current bit stays on bit_out for another clock.
  - Edge with stall=0 and bits_left>1: shift left by 1, fill LSB with 0, bit_out<=new MSB, bits_left-=1.
  - Edge with stall=0 and bits_left=1: bit_out<=0, bit_valid<=0, bits_left<=0, done<=1, go to DONE.
  - stall=1 on the final bit keeps it held; done is delayed accordingly.
- DONE: lasts exactly one cycle (done=1, load_ready=0), then returns to IDLE with done<=0.
- Latency:
  - First bit appears on bit_out the cycle after load acceptance.
  - With no stalls, bit k (0 = MSB) is valid in cycle k+1 after the accepting edge; done asserts in cycle WIDTH+1.
  - Minimum load-to-load spacing is WIDTH+2 cycles.
- Invariants:
  - bit_out=0 whenever bit_valid=0.
  - bits_left never underflows; it is 0 outside SHIFT.
- Reset mid-operation: the pattern is abandoned and outputs return to their reset values asynchronously. The first edge after rst deasserts behaves as IDLE.
- Simultaneous rst and load_valid: rst wins and nothing is captured.

Optional Feature:
Macro SEQ_SERIALIZER_LOOP_EN.
- Defined:
  - Adds input port loop_mode (1 bit) and a WIDTH-bit copy register loaded with load_data on acceptance.
  - In SHIFT, when the last bit completes (stall=0, bits_left=1) and loop_mode=1: reload the shift register from the copy, bits_left<=WIDTH, bit_out<=copy[WIDTH-1], stay in SHIFT with bit_valid=1.
  - done pulses 1 for that one cycle as the pattern wraps.
  - Dropping loop_mode takes effect at the next pattern end, which then proceeds to DONE normally.
- Undefined: no loop_mode port, no copy register; behaviour exactly as above.

Test Plan:
1. Reset: hold rst=1 for 30 ns mid-clock -> bit_out=0, bit_valid=0, busy=0, done=0, bits_left=0, load_ready=1 without waiting for a clock edge.
2. Basic shift: load 0x4A469485 (WIDTH=32), stall=0 -> bit_out over 32 consecutive cycles = 0,1,0,0,1,0,1,0,... ending 0,1,0,1; bits_left counts 32 down to 1; done=1 exactly in cycle 33; load_ready=1 again in cycle 34.
3. Stall: load 0xEFD62A8D; assert stall for 3 cycles when bits_left=20 -> bit_out and bits_left held for 4 cycles total; done in cycle 36; serial sequence unchanged.
4. Ignored load: while busy, pulse load_valid with 0xFFFFFFFF -> load_ready=0, output sequence still matches the original pattern; no capture.
5. Reset mid-pattern: assert rst asynchronously when bits_left=10 -> all outputs to reset values immediately; after release, loading 0xA3D6B2F4 produces its full 32 bits from the MSB.
6. With SEQ_SERIALIZER_LOOP_EN: load 0x55F4DD62, loop_mode=1 for 2 passes then 0 -> 96 contiguous valid bits (pattern x3); done pulses in cycles 33, 65 and 97; bit_valid has no gaps until the third done.
